// File: rtl/instance_expander.sv
// Instance expander: queues scene instances, requests each model in order and
// pairs every returned triangle with its instance transform.
// Optional per-scene output counter: define INSTANCE_EXPANDER_STATS_EN.
module instance_expander #(
  parameter int XFORM_W     = 192,
  parameter int TRI_W       = 288,
  parameter int MODEL_ID_W  = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [XFORM_W-1:0]    inst_xform,
  input  logic [MODEL_ID_W-1:0] inst_model_id,
  input  logic                  inst_last,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [MODEL_ID_W-1:0] req_model_id,
  input  logic                  tri_valid,
  output logic                  tri_ready,
  input  logic [TRI_W-1:0]      tri_data,
  input  logic                  tri_last,
  input  logic                  tri_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XFORM_W-1:0]    out_xform,
  output logic [TRI_W-1:0]      out_tri,
  output logic                  out_last_model,
  output logic                  out_last_scene,
  output logic                  scene_done
`ifdef INSTANCE_EXPANDER_STATS_EN
  ,
  output logic [31:0]           stat_tri_count
`endif
);

  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int PTR_W = AW + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e state_q, state_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   iss_ptr_q, iss_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  logic   run_q, run_d;

  logic               out_valid_q, out_valid_d;
  logic [XFORM_W-1:0] out_xform_q, out_xform_d;
  logic [TRI_W-1:0]   out_tri_q, out_tri_d;
  logic               out_last_model_q, out_last_model_d;
  logic               out_last_scene_q, out_last_scene_d;
  logic               scene_done_q, scene_done_d;

  logic [XFORM_W-1:0]    xform_mem [QUEUE_DEPTH];
  logic [MODEL_ID_W-1:0] model_mem [QUEUE_DEPTH];
  logic                  last_mem  [QUEUE_DEPTH];

  logic [AW-1:0] wr_idx, iss_idx, rd_idx;
  logic          full, head_req, can_load;
  logic          push, req_fire, tri_fire, load, pop, out_fire;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign iss_idx = iss_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];

  // Full when the index bits match but the wrap bits differ.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign head_req = (iss_ptr_q != rd_ptr_q);
  assign can_load = !out_valid_q || out_ready;

  // run_q holds the ready outputs low for the first cycle after reset.
  assign inst_ready   = run_q && !full;
  assign req_valid    = (state_q == S_ISSUE);
  assign req_model_id = req_valid ? model_mem[iss_idx] : '0;
  assign tri_ready    = head_req && can_load;

  assign push     = inst_valid && inst_ready;
  assign req_fire = req_valid && req_ready;
  assign tri_fire = tri_valid && tri_ready;
  assign load     = tri_fire && !tri_empty;
  assign pop      = tri_fire && (tri_last || tri_empty);
  assign out_fire = out_valid_q && out_ready;

  assign out_valid      = out_valid_q;
  assign out_xform      = out_xform_q;
  assign out_tri        = out_tri_q;
  assign out_last_model = out_last_model_q;
  assign out_last_scene = out_last_scene_q;
  assign scene_done     = scene_done_q;

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    iss_ptr_d        = iss_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    run_d            = 1'b1;
    out_valid_d      = out_valid_q;
    out_xform_d      = out_xform_q;
    out_tri_d        = out_tri_q;
    out_last_model_d = out_last_model_q;
    out_last_scene_d = out_last_scene_q;
    scene_done_d     = pop && last_mem[rd_idx];

    if (push)     wr_ptr_d  = wr_ptr_q + PTR_W'(1);
    if (req_fire) iss_ptr_d = iss_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d  = rd_ptr_q + PTR_W'(1);

    if (load) begin
      out_valid_d      = 1'b1;
      out_xform_d      = xform_mem[rd_idx];
      out_tri_d        = tri_data;
      out_last_model_d = tri_last;
      out_last_scene_d = tri_last && last_mem[rd_idx];
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iss_ptr_d != wr_ptr_d) state_d = S_ISSUE;
      S_ISSUE: if (iss_ptr_d == wr_ptr_d) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      wr_ptr_q         <= '0;
      iss_ptr_q        <= '0;
      rd_ptr_q         <= '0;
      run_q            <= 1'b0;
      out_valid_q      <= 1'b0;
      out_xform_q      <= '0;
      out_tri_q        <= '0;
      out_last_model_q <= 1'b0;
      out_last_scene_q <= 1'b0;
      scene_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      iss_ptr_q        <= iss_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      run_q            <= run_d;
      out_valid_q      <= out_valid_d;
      out_xform_q      <= out_xform_d;
      out_tri_q        <= out_tri_d;
      out_last_model_q <= out_last_model_d;
      out_last_scene_q <= out_last_scene_d;
      scene_done_q     <= scene_done_d;
    end
  end

  // NOTE: queue storage is not reset; entries are only read between the
  // read and write pointers, which reset does clear.
  always_ff @(posedge clk) begin
    if (push) begin
      xform_mem[wr_idx] <= inst_xform;
      model_mem[wr_idx] <= inst_model_id;
      last_mem[wr_idx]  <= inst_last;
    end
  end

`ifdef INSTANCE_EXPANDER_STATS_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (scene_done_q)                    stat_d = '0;
    else if (out_fire && stat_q != '1)   stat_d = stat_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_tri_count = stat_q;
`endif

endmodule

// File: tb/tb_instance_expander.sv
// Directed self-checking bench for instance_expander (default parameters).
module tb_instance_expander;

  localparam int XW = 192;
  localparam int TW = 288;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_valid, inst_ready, inst_last;
  logic [XW-1:0] inst_xform;
  logic [MW-1:0] inst_model_id;
  logic          req_valid, req_ready;
  logic [MW-1:0] req_model_id;
  logic          tri_valid, tri_ready, tri_last, tri_empty;
  logic [TW-1:0] tri_data;
  logic          out_valid, out_ready, out_last_model, out_last_scene;
  logic [XW-1:0] out_xform;
  logic [TW-1:0] out_tri;
  logic          scene_done;
`ifdef INSTANCE_EXPANDER_STATS_EN
  logic [31:0]   stat_tri_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instance_expander dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_xform(inst_xform),
    .inst_model_id(inst_model_id), .inst_last(inst_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_model_id(req_model_id),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
    .tri_last(tri_last), .tri_empty(tri_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_xform(out_xform),
    .out_tri(out_tri), .out_last_model(out_last_model),
    .out_last_scene(out_last_scene), .scene_done(scene_done)
`ifdef INSTANCE_EXPANDER_STATS_EN
    , .stat_tri_count(stat_tri_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [XW-1:0] mk_x(input logic [7:0] b);
    return {24{b}};
  endfunction

  function automatic logic [TW-1:0] mk_t(input logic [7:0] b);
    return {36{b}};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [XW-1:0] xf, input logic [MW-1:0] mid, input logic last);
    bit ok = 1'b0;
    inst_valid = 1'b1; inst_xform = xf; inst_model_id = mid; inst_last = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = inst_ready;
      step();
    end
    inst_valid = 1'b0;
    check("push_timeout", ok, 1'b1);
  endtask

  task automatic accept_req(input logic [MW-1:0] mid);
    bit ok = 1'b0;
    logic [MW-1:0] got = '0;
    req_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = req_valid;
      if (ok) got = req_model_id;
      step();
    end
    req_ready = 1'b0;
    check("req_timeout", ok, 1'b1);
    check("req_model_id", got, mid);
  endtask

  task automatic send_beat(input logic [TW-1:0] d, input logic last, input logic empty);
    bit ok = 1'b0;
    tri_valid = 1'b1; tri_data = d; tri_last = last; tri_empty = empty;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = tri_ready;
      step();
    end
    tri_valid = 1'b0; tri_last = 1'b0; tri_empty = 1'b0; tri_data = '0;
    check("beat_timeout", ok, 1'b1);
  endtask

  task automatic expect_out(input string tag, input logic [XW-1:0] xf, input logic [TW-1:0] t,
                            input logic lm, input logic ls, input logic sd);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_xform"}, out_xform, xf);
    check({tag, "_tri"}, out_tri, t);
    check({tag, "_last_model"}, out_last_model, lm);
    check({tag, "_last_scene"}, out_last_scene, ls);
    check({tag, "_scene_done"}, scene_done, sd);
  endtask

  initial begin
    rst = 1'b1;
    inst_valid = 1'b0; inst_xform = '0; inst_model_id = '0; inst_last = 1'b0;
    req_ready = 1'b0;
    tri_valid = 1'b0; tri_data = '0; tri_last = 1'b0; tri_empty = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_inst_ready", inst_ready, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_tri_ready", tri_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_scene_done", scene_done, 1'b0);
    check("rst_out_xform", out_xform, '0);
    check("rst_out_tri", out_tri, '0);
    check("rst_req_model_id", req_model_id, '0);
    check("rst_last_flags", {out_last_model, out_last_scene}, 2'b00);
`ifdef INSTANCE_EXPANDER_STATS_EN
    check("rst_stat", stat_tri_count, 32'd0);
`endif
    rst = 1'b0;
    step();
    check("post_rst_inst_ready", inst_ready, 1'b1);

    // Single instance, model 3, three triangles
    push_inst(mk_x(8'hA1), 4'd3, 1'b1);
    accept_req(4'd3);
    check("s1_req_once", req_valid, 1'b0);
    send_beat(mk_t(8'h10), 1'b0, 1'b0);
    expect_out("s1_t0", mk_x(8'hA1), mk_t(8'h10), 1'b0, 1'b0, 1'b0);
    send_beat(mk_t(8'h11), 1'b0, 1'b0);
    expect_out("s1_t1", mk_x(8'hA1), mk_t(8'h11), 1'b0, 1'b0, 1'b0);
    send_beat(mk_t(8'h12), 1'b1, 1'b0);
    expect_out("s1_t2", mk_x(8'hA1), mk_t(8'h12), 1'b1, 1'b1, 1'b1);
    step();
    check("s1_done_pulse_end", scene_done, 1'b0);
    check("s1_drained", out_valid, 1'b0);

    // Two instances back to back, both requested before triangles arrive
    push_inst(mk_x(8'hB2), 4'd1, 1'b0);
    push_inst(mk_x(8'hC3), 4'd2, 1'b1);
    check("s2_full", inst_ready, 1'b0);
    accept_req(4'd1);
    accept_req(4'd2);
    check("s2_both_issued", req_valid, 1'b0);
    send_beat(mk_t(8'h20), 1'b0, 1'b0);
    expect_out("s2_b0", mk_x(8'hB2), mk_t(8'h20), 1'b0, 1'b0, 1'b0);
    send_beat(mk_t(8'h21), 1'b1, 1'b0);
    expect_out("s2_b1", mk_x(8'hB2), mk_t(8'h21), 1'b1, 1'b0, 1'b0);
    send_beat(mk_t(8'h30), 1'b1, 1'b0);
    expect_out("s2_c0", mk_x(8'hC3), mk_t(8'h30), 1'b1, 1'b1, 1'b1);
    step();
    check("s2_drained", out_valid, 1'b0);

    // Empty model 5 on the scene's last instance
    push_inst(mk_x(8'hE5), 4'd5, 1'b1);
    accept_req(4'd5);
    send_beat('0, 1'b1, 1'b1);
    check("s3_no_out", out_valid, 1'b0);
    check("s3_scene_done", scene_done, 1'b1);
    step();
    check("s3_done_pulse_end", scene_done, 1'b0);
    check("s3_still_no_out", out_valid, 1'b0);
    check("s3_queue_empty", {req_valid, tri_ready}, 2'b00);

    // Downstream stall for 10 cycles mid-model
    push_inst(mk_x(8'hD4), 4'd4, 1'b1);
    accept_req(4'd4);
    send_beat(mk_t(8'h40), 1'b0, 1'b0);
    expect_out("s4_d0", mk_x(8'hD4), mk_t(8'h40), 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    tri_valid = 1'b1; tri_data = mk_t(8'h41); tri_last = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("s4_stall_tri_ready", tri_ready, 1'b0);
      step();
      check("s4_stall_valid", out_valid, 1'b1);
      check("s4_stall_tri", out_tri, mk_t(8'h40));
    end
    out_ready = 1'b1;
    #1;
    check("s4_release_tri_ready", tri_ready, 1'b1);
    step();
    tri_valid = 1'b0; tri_last = 1'b0; tri_data = '0;
    expect_out("s4_d1", mk_x(8'hD4), mk_t(8'h41), 1'b1, 1'b1, 1'b1);
    step();
    check("s4_drained", out_valid, 1'b0);

    // Full queue: pop and push offered together, push refused
    push_inst(mk_x(8'hF6), 4'd6, 1'b0);
    push_inst(mk_x(8'h97), 4'd7, 1'b1);
    check("s5_full", inst_ready, 1'b0);
    accept_req(4'd6);
    tri_valid = 1'b1; tri_data = mk_t(8'h60); tri_last = 1'b1;
    inst_valid = 1'b1; inst_xform = mk_x(8'h88); inst_model_id = 4'd8; inst_last = 1'b0;
    #1;
    check("s5_push_refused", inst_ready, 1'b0);
    check("s5_pop_ready", tri_ready, 1'b1);
    step();
    inst_valid = 1'b0;
    tri_valid = 1'b0; tri_last = 1'b0; tri_data = '0;
    check("s5_count_dec", inst_ready, 1'b1);
    expect_out("s5_f0", mk_x(8'hF6), mk_t(8'h60), 1'b1, 1'b0, 1'b0);
    check("s5_g_pending", req_valid, 1'b1);
    accept_req(4'd7);
    check("s5_nothing_extra", req_valid, 1'b0);
    send_beat(mk_t(8'h70), 1'b1, 1'b0);
    expect_out("s5_g0", mk_x(8'h97), mk_t(8'h70), 1'b1, 1'b1, 1'b1);
    step();
    check("s5_drained", {inst_ready, out_valid}, 2'b10);

    // Seven outputs, then an empty last instance ends the scene
`ifdef INSTANCE_EXPANDER_STATS_EN
    check("s6_stat_start", stat_tri_count, 32'd0);
`endif
    push_inst(mk_x(8'h51), 4'd1, 1'b0);
    accept_req(4'd1);
    push_inst(mk_x(8'h52), 4'd2, 1'b0);
    accept_req(4'd2);
    for (int i = 0; i < 4; i++) begin
      send_beat(mk_t(8'h80 + 8'(i)), (i == 3), 1'b0);
      expect_out("s6_x", mk_x(8'h51), mk_t(8'h80 + 8'(i)), (i == 3), 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      send_beat(mk_t(8'h90 + 8'(i)), (i == 2), 1'b0);
      expect_out("s6_y", mk_x(8'h52), mk_t(8'h90 + 8'(i)), (i == 2), 1'b0, 1'b0);
    end
    step();
    check("s6_drained", out_valid, 1'b0);
`ifdef INSTANCE_EXPANDER_STATS_EN
    check("s6_stat_7", stat_tri_count, 32'd7);
`endif
    push_inst(mk_x(8'h53), 4'd5, 1'b1);
    accept_req(4'd5);
    send_beat('0, 1'b1, 1'b1);
    check("s6_scene_done", scene_done, 1'b1);
`ifdef INSTANCE_EXPANDER_STATS_EN
    check("s6_stat_held", stat_tri_count, 32'd7);
`endif
    step();
`ifdef INSTANCE_EXPANDER_STATS_EN
    check("s6_stat_cleared", stat_tri_count, 32'd0);
`endif
    check("s6_done_pulse_end", scene_done, 1'b0);

    // Reset in the middle of a model
    push_inst(mk_x(8'hCC), 4'd9, 1'b1);
    accept_req(4'd9);
    send_beat(mk_t(8'hAA), 1'b0, 1'b0);
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_out_tri", out_tri, '0);
    check("mr_readies", {inst_ready, req_valid, tri_ready, scene_done}, 4'b0000);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("mr_recovered", {inst_ready, req_valid, tri_ready, out_valid}, 4'b1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instance_expander.md
INSTANCE_EXPANDER -- requirements
Module: instance_expander

Interface
- REQ-001 SHALL have parameter XFORM_W, default 192: transform payload width.
- REQ-002 SHALL have parameter TRI_W, default 288: triangle payload width.
- REQ-003 SHALL have parameter MODEL_ID_W, default 4: model index width.
- REQ-004 SHALL have parameter QUEUE_DEPTH, default 2: instance queue entries; power of two, at least 2.
- REQ-005 SHALL have the following ports, clock and reset first:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  reset, synchronous, active-high.
  - inst_valid  in  1  instance offered.
  - inst_ready  out  1  instance accepted.
  - inst_xform  in  XFORM_W  instance transform.
  - inst_model_id  in  MODEL_ID_W  model to expand.
  - inst_last  in  1  last instance of scene.
  - req_valid  out  1  model read request.
  - req_ready  in  1  request accepted.
  - req_model_id  out  MODEL_ID_W  requested model.
  - tri_valid  in  1  triangle beat offered.
  - tri_ready  out  1  triangle beat accepted.
  - tri_data  in  TRI_W  triangle.
  - tri_last  in  1  final beat of model.
  - tri_empty  in  1  model has zero triangles; beat carries no data and SHALL also have tri_last=1.
  - out_valid  out  1  paired output valid.
  - out_ready  in  1  downstream ready.
  - out_xform  out  XFORM_W  transform.
  - out_tri  out  TRI_W  triangle.
  - out_last_model  out  1  last triangle of this instance.
  - out_last_scene  out  1  last triangle of scene.
  - scene_done  out  1  one-cycle pulse when the scene's last instance retires.

Function
- REQ-006 SHALL transfer on any interface only in a cycle where valid and ready are both 1; valid, once high, SHALL hold with stable payload until that transfer.
- REQ-007 SHALL store accepted instances in a FIFO of QUEUE_DEPTH entries; inst_ready SHALL be 1 exactly when the FIFO is not full; inst_ready SHALL NOT depend on the same-cycle inst_valid.
- REQ-008 SHALL issue one request per queued entry, in FIFO order, through a separate issue pointer; req_valid SHALL be 1 while any entry is unrequested; up to QUEUE_DEPTH requests SHALL be outstanding at once.
- REQ-009 SHALL treat triangle beats as responses in request order; tri_ready SHALL be 1 only when the head entry is requested and the output register is empty or being drained this cycle.
- REQ-010 SHALL load the output register from each accepted non-empty beat as follows, with latency one cycle from tri transfer to out_valid:
  - out_xform = head transform.
  - out_tri = tri_data.
  - out_last_model = tri_last.
  - out_last_scene = tri_last AND head inst_last.
- REQ-011 SHALL pop the head entry on an accepted beat with tri_last=1.
- REQ-012 SHALL, on a tri_empty beat, produce no output and pop the head entry in the same cycle.
- REQ-013 SHALL pulse scene_done on the cycle after the pop of any entry with inst_last=1, including a pop caused by an empty model.
- REQ-014 SHALL allow push, request issue and pop in the same cycle; a full FIFO popping SHALL NOT accept a push that cycle.
- REQ-015 SHALL wrap all pointers modulo QUEUE_DEPTH, with one extra wrap bit to distinguish full from empty.
- REQ-016 SHALL be a single-issuer design with two states, IDLE (no unrequested entry) and ISSUE (req_valid=1); ISSUE SHALL return to IDLE when the issue pointer reaches the write pointer.

Reset
- REQ-017 SHALL, when rst=1 at a clock edge, empty the FIFO, clear all pointers and the output register, and drive inst_ready=0, req_valid=0, tri_ready=0, out_valid=0, scene_done=0 and every payload output to 0 on the following cycle.
- REQ-018 SHALL, when reset is asserted mid-expansion, discard outstanding requests and in-flight instances; the upstream is reset together with this block.

Configuration
- REQ-019 SHALL, when macro INSTANCE_EXPANDER_STATS_EN is defined, add output stat_tri_count, 32 bits, which:
  - counts out transfers;
  - clears on reset;
  - clears on the cycle following scene_done;
  - saturates at all-ones.
- REQ-020 SHALL, when INSTANCE_EXPANDER_STATS_EN is not defined, have neither the port nor the counter logic.

Verification
- REQ-021 The bench SHALL cover these directed scenarios:
  - One instance (model 3, xform A, last=1); 3 triangle beats T0..T2 → req_model_id=3 once, outputs (A,T0),(A,T1),(A,T2 with out_last_model=1 and out_last_scene=1), scene_done pulses once.
  - Two instances pushed back-to-back, depth 2 → two requests issued before the first model's triangles end, and the outputs are not interleaved.
  - Instance with model 5 answered by a tri_empty beat, last=1 → no out_valid, and scene_done pulses one cycle after the pop.
  - out_ready held 0 for 10 cycles mid-model → out payload stable, tri_ready=0, and no beat is lost.
  - FIFO full with a simultaneous pop and push offered → push refused, count decrements by 1.
  - With INSTANCE_EXPANDER_STATS_EN, 7 output transfers → stat_tri_count=7, then 0 after scene_done.
